// File: rtl/odd_pkg.sv
// Shared types and latency table for the odd-pipe issue controller.
package odd_pkg;
  localparam int REG_W    = 7;
  localparam int LAT_PERM = 4;
  localparam int LAT_LS   = 6;
  localparam int LAT_BR   = 1;

  typedef enum logic [1:0] {
    UNIT_PERM = 2'd0,
    UNIT_LS   = 2'd1,
    UNIT_BR   = 2'd2
  } unit_e;

  // Result latency of a unit; the unused encoding 3 behaves like perm.
  function automatic logic [2:0] lat_of(input logic [1:0] unit);
    case (unit)
      UNIT_LS: lat_of = 3'(LAT_LS);
      UNIT_BR: lat_of = 3'(LAT_BR);
      default: lat_of = 3'(LAT_PERM);
    endcase
  endfunction
endpackage

// File: rtl/odd_scoreboard.sv
// Ring of in-flight destination registers, each counting down to forwarding availability.
module odd_scoreboard
  import odd_pkg::*;
#(
  parameter int NSLOT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc,
  input  logic [REG_W-1:0]      alloc_addr,
  input  logic [2:0]            alloc_cnt,
  input  logic [3:0][REG_W-1:0] q_addr,
  output logic [3:0]            q_busy
);
  localparam int PW = $clog2(NSLOT);

  logic [REG_W-1:0] addr [NSLOT];
  logic [2:0]       cnt  [NSLOT];
  logic [PW-1:0]    wr_ptr;

  // The new entry's write wins over its own decrement on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        cnt[i]  <= '0;
        addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSLOT; i++)
        if (cnt[i] != 3'd0) cnt[i] <= cnt[i] - 3'd1;
      if (alloc) begin
        cnt[wr_ptr]  <= alloc_cnt;
        addr[wr_ptr] <= alloc_addr;
        wr_ptr       <= wr_ptr + PW'(1);
      end
    end
  end

  always_comb begin
    q_busy = '0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < NSLOT; i++)
        if (cnt[i] != 3'd0 && addr[i] == q_addr[k]) q_busy[k] = 1'b1;
  end

  a_no_overwrite: assert property (@(posedge clk) disable iff (reset)
    alloc |-> cnt[wr_ptr] == 3'd0);
endmodule

// File: rtl/odd_issue_ctrl.sv
// Odd-pipe issue stage: hazard-gated handshake, registered issue port and perf counters.
module odd_issue_ctrl
  import odd_pkg::*;
#(
  parameter int NSLOT = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_unit,
  input  logic [6:0]       in_rt_addr,
  input  logic [6:0]       in_ra_addr,
  input  logic [6:0]       in_rb_addr,
  input  logic [6:0]       in_rc_addr,
  input  logic             in_ra_use,
  input  logic             in_rb_use,
  input  logic             in_rc_use,
  input  logic             in_reg_write,
  input  logic             ext_stall,
  input  logic             flush,
  output logic             issue_valid,
  output logic [1:0]       issue_unit,
  output logic [6:0]       issue_rt_addr,
  output logic             issue_reg_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] issue_cnt
);
  logic [3:0] busy;
  logic [2:0] lat;
  logic       hazard, accept, alloc;

  assign lat    = lat_of(in_unit);
  assign alloc  = accept && in_reg_write && (lat > 3'd1);

  odd_scoreboard #(.NSLOT(NSLOT)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .alloc      (alloc),
    .alloc_addr (in_rt_addr),
    .alloc_cnt  (lat - 3'd1),
    .q_addr     ({in_rt_addr, in_rc_addr, in_rb_addr, in_ra_addr}),
    .q_busy     (busy)
  );

  // Ready never looks at in_valid, keeping the handshake loop-free.
  assign hazard   = (in_ra_use & busy[0]) | (in_rb_use & busy[1]) |
                    (in_rc_use & busy[2]) | (in_reg_write & busy[3]);
  assign in_ready = !reset && !hazard && !ext_stall && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid     <= 1'b0;
      issue_unit      <= '0;
      issue_rt_addr   <= '0;
      issue_reg_write <= 1'b0;
      stall_cnt       <= '0;
      issue_cnt       <= '0;
    end else begin
      issue_valid     <= accept;
      issue_reg_write <= accept && in_reg_write;
      if (accept) begin
        issue_unit    <= in_unit;
        issue_rt_addr <= in_rt_addr;
      end
      if (in_valid && !in_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (accept && issue_cnt != '1) issue_cnt <= issue_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_odd_issue_ctrl.sv
// Bench for odd_issue_ctrl: directed scenarios plus a random stream against a timestamp model.
module tb_odd_issue_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [1:0] U_PERM = 2'd0, U_LS = 2'd1, U_BR = 2'd2;

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [1:0] in_unit = '0;
  logic [6:0] in_rt_addr = '0, in_ra_addr = '0, in_rb_addr = '0, in_rc_addr = '0;
  logic in_ra_use = 1'b0, in_rb_use = 1'b0, in_rc_use = 1'b0, in_reg_write = 1'b0;
  logic ext_stall = 1'b0, flush = 1'b0;
  logic issue_valid, issue_reg_write;
  logic [1:0] issue_unit;
  logic [6:0] issue_rt_addr;
  logic [CNT_W-1:0] stall_cnt, issue_cnt;

  always #5 clk = ~clk;

  odd_issue_ctrl #(.NSLOT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_unit(in_unit),
    .in_rt_addr(in_rt_addr), .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
    .in_rc_addr(in_rc_addr), .in_ra_use(in_ra_use), .in_rb_use(in_rb_use),
    .in_rc_use(in_rc_use), .in_reg_write(in_reg_write), .ext_stall(ext_stall), .flush(flush),
    .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_rt_addr(issue_rt_addr),
    .issue_reg_write(issue_reg_write), .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int rdy_at [128];   // cycle from which each register's result is forwardable
  int m_stall = 0, m_issue = 0;
  bit m_iv = 0, m_irw = 0;
  logic [1:0] m_iu = '0;
  logic [6:0] m_irt = '0;

  function automatic int lat(input logic [1:0] u);
    return (u == U_LS) ? 6 : (u == U_BR) ? 1 : 4;
  endfunction

  function automatic bit m_ready();
    if (reset || ext_stall || flush) return 0;
    if (in_ra_use && rdy_at[in_ra_addr] > cyc) return 0;
    if (in_rb_use && rdy_at[in_rb_addr] > cyc) return 0;
    if (in_rc_use && rdy_at[in_rc_addr] > cyc) return 0;
    if (in_reg_write && rdy_at[in_rt_addr] > cyc) return 0;
    return 1;
  endfunction

  // Advance one clock (negedge to negedge), updating the model from the inputs at the edge.
  task automatic step();
    bit acc;
    @(posedge clk);
    acc = in_valid && m_ready();
    if (reset) begin
      foreach (rdy_at[i]) rdy_at[i] = 0;
      m_stall = 0; m_issue = 0; m_iv = 0; m_irw = 0; m_iu = '0; m_irt = '0;
    end else begin
      if (in_valid && !acc && m_stall < CMAX) m_stall++;
      if (acc && m_issue < CMAX) m_issue++;
      if (acc && in_reg_write && lat(in_unit) > 1) rdy_at[in_rt_addr] = cyc + lat(in_unit);
      m_iv = acc;
      m_irw = acc && in_reg_write;
      if (acc) begin m_iu = in_unit; m_irt = in_rt_addr; end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_in(input bit v, input logic [1:0] u, input logic [6:0] rt,
                        input logic [6:0] ra, input bit rau, input bit rw);
    in_valid = v; in_unit = u; in_rt_addr = rt; in_ra_addr = ra; in_ra_use = rau;
    in_rb_addr = 7'd120; in_rb_use = 1'b0; in_rc_addr = 7'd121; in_rc_use = 1'b0;
    in_reg_write = rw;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; ext_stall = 1'b0;
    set_in(0, U_PERM, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1, U_LS, 3, 4, 1, 1);
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", in_ready); end
    step(); step();
    n_chk++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iv got %b want 0", issue_valid); end
    n_chk++; if (issue_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_irw got %b want 0", issue_reg_write); end
    n_chk++; if (issue_unit !== 2'd0) begin n_fail++; $display("FAIL reset_iu got %0d want 0", issue_unit); end
    n_chk++; if (issue_rt_addr !== 7'd0) begin n_fail++; $display("FAIL reset_irt got %0d want 0", issue_rt_addr); end
    n_chk++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    n_chk++; if (issue_cnt !== '0) begin n_fail++; $display("FAIL reset_issue got %0d want 0", issue_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_independent();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1, U_PERM, 7'(10 + i), 7'(40 + i), 1, 1);
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL indep_ready i=%0d got %b want 1", i, in_ready); end
      step();
      n_chk++; if (issue_valid !== 1'b1 || issue_rt_addr !== 7'(10 + i)) begin
        n_fail++; $display("FAIL indep_issue i=%0d got v=%b rt=%0d want v=1 rt=%0d", i, issue_valid, issue_rt_addr, 10 + i);
      end
    end
    set_in(0, U_PERM, 0, 0, 0, 0);
    step();
    n_chk++; if (issue_valid !== 1'b0 || issue_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL indep_idle got v=%b rw=%b want 0 0", issue_valid, issue_reg_write);
    end
    n_chk++; if (issue_cnt !== 4'd10 || stall_cnt !== 4'd0) begin
      n_fail++; $display("FAIL indep_cnt got issue=%0d stall=%0d want 10 0", issue_cnt, stall_cnt);
    end
  endtask

  task automatic test_raw(input logic [1:0] u, input int l);
    int w;
    do_reset();
    set_in(1, u, 5, 100, 0, 1);
    step();
    set_in(1, U_PERM, 50, 5, 1, 1);
    w = 0;
    while (!in_ready && w < 20) begin step(); w++; end
    n_chk++; if (w != l - 1) begin n_fail++; $display("FAIL raw_wait unit=%0d got %0d want %0d", u, w, l - 1); end
    n_chk++; if (stall_cnt !== 4'(l - 1)) begin n_fail++; $display("FAIL raw_stall unit=%0d got %0d want %0d", u, stall_cnt, l - 1); end
    step();
    n_chk++; if (issue_valid !== 1'b1 || issue_rt_addr !== 7'd50) begin
      n_fail++; $display("FAIL raw_issue got v=%b rt=%0d want 1 50", issue_valid, issue_rt_addr);
    end
  endtask

  task automatic test_br_waw();
    int w;
    do_reset();
    set_in(1, U_BR, 9, 100, 0, 1);
    step();
    set_in(1, U_PERM, 51, 9, 1, 1);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL br_b2b got %b want 1", in_ready); end
    step();
    n_chk++; if (issue_valid !== 1'b1 || issue_rt_addr !== 7'd51) begin
      n_fail++; $display("FAIL br_issue got v=%b rt=%0d want 1 51", issue_valid, issue_rt_addr);
    end
    set_in(1, U_LS, 7, 100, 0, 1);
    step();
    n_chk++; if (issue_unit !== U_LS || issue_reg_write !== 1'b1) begin
      n_fail++; $display("FAIL ls_issue got u=%0d rw=%b want 1 1", issue_unit, issue_reg_write);
    end
    set_in(1, U_PERM, 7, 101, 0, 1);
    w = 0;
    while (!in_ready && w < 20) begin step(); w++; end
    n_chk++; if (w != 5) begin n_fail++; $display("FAIL waw_wait got %0d want 5", w); end
    step();
    n_chk++; if (issue_rt_addr !== 7'd7 || issue_unit !== U_PERM) begin
      n_fail++; $display("FAIL waw_issue got rt=%0d u=%0d want 7 0", issue_rt_addr, issue_unit);
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    set_in(1, U_PERM, 20, 100, 0, 1);
    step();
    flush = 1'b1;
    set_in(1, U_PERM, 30, 31, 1, 1);
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", in_ready); end
    step();
    n_chk++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_iv got %b want 0", issue_valid); end
    flush = 1'b0; #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_next got %b want 1", in_ready); end
    step();
    set_in(1, U_PERM, 60, 20, 1, 1);
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_raw_t3 got %b want 0", in_ready); end
    step();
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_raw_t4 got %b want 1", in_ready); end
    step();
    ext_stall = 1'b1;
    set_in(1, U_PERM, 70, 71, 1, 1);
    for (int i = 0; i < 3; i++) step();
    n_chk++; if (stall_cnt !== 4'd5) begin n_fail++; $display("FAIL ext_stall_cnt got %0d want 5", stall_cnt); end
    flush = 1'b1; #1;
    step();
    n_chk++; if (stall_cnt !== 4'd6) begin n_fail++; $display("FAIL both_stall_cnt got %0d want 6", stall_cnt); end
    flush = 1'b0; ext_stall = 1'b0; #1;
    step();
    n_chk++; if (issue_cnt !== 4'd4 || issue_rt_addr !== 7'd70) begin
      n_fail++; $display("FAIL flush_final got cnt=%0d rt=%0d want 4 70", issue_cnt, issue_rt_addr);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      set_in(1, U_LS, 7'(i), 100, 0, 1);
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ls_ready r=%0d got %b want 1", i, in_ready); end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      set_in(1, U_PERM, 7'(11 + i), 101, 0, 1);
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_perm_ready i=%0d got %b want 1", i, in_ready); end
      step();
    end
    set_in(1, U_PERM, 0, 6, 1, 1);
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_hold_r6 got %b want 0", in_ready); end
    step();
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_free_r6 got %b want 1", in_ready); end
    step();
    for (int i = 1; i <= 6; i++) begin
      set_in(1, U_LS, 7'(i), 100, 0, 1);
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wrap2_ready r=%0d got %b want 1", i, in_ready); end
      step();
    end
    reset = 1'b1;
    set_in(1, U_PERM, 33, 6, 1, 1);
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready got %b want 0", in_ready); end
    step();
    n_chk++; if (issue_valid !== 1'b0 || issue_reg_write !== 1'b0 || issue_unit !== 2'd0 || issue_rt_addr !== 7'd0) begin
      n_fail++; $display("FAIL midreset_issue got v=%b rw=%b u=%0d rt=%0d want all 0", issue_valid, issue_reg_write, issue_unit, issue_rt_addr);
    end
    n_chk++; if (stall_cnt !== '0 || issue_cnt !== '0) begin
      n_fail++; $display("FAIL midreset_cnt got stall=%0d issue=%0d want 0 0", stall_cnt, issue_cnt);
    end
    reset = 1'b0; #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL postreset_r6 got %b want 1", in_ready); end
    step();
    n_chk++; if (issue_valid !== 1'b1 || issue_rt_addr !== 7'd33 || issue_cnt !== 4'd1) begin
      n_fail++; $display("FAIL postreset_issue got v=%b rt=%0d cnt=%0d want 1 33 1", issue_valid, issue_rt_addr, issue_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ext_stall = 1'b1;
    set_in(1, U_PERM, 1, 2, 1, 1);
    for (int i = 0; i < 20; i++) step();
    n_chk++; if (stall_cnt !== 4'd15 || issue_cnt !== 4'd0) begin
      n_fail++; $display("FAIL sat_stall got stall=%0d issue=%0d want 15 0", stall_cnt, issue_cnt);
    end
    ext_stall = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_unit      = 2'($urandom_range(0, 3));
      in_rt_addr   = 7'($urandom_range(0, 7));
      in_ra_addr   = 7'($urandom_range(0, 7));
      in_rb_addr   = 7'($urandom_range(0, 7));
      in_rc_addr   = 7'($urandom_range(0, 7));
      in_ra_use    = 1'($urandom_range(0, 1));
      in_rb_use    = 1'($urandom_range(0, 1));
      in_rc_use    = 1'($urandom_range(0, 1));
      in_reg_write = ($urandom_range(0, 3) != 0);
      ext_stall    = ($urandom_range(0, 9) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      reset        = ($urandom_range(0, 79) == 0);
      #1;
      n_chk++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready n=%0d got %b want %b", n, in_ready, m_ready()); end
      step();
      n_chk++; if (issue_valid !== m_iv || issue_reg_write !== m_irw || issue_unit !== m_iu || issue_rt_addr !== m_irt) begin
        n_fail++; $display("FAIL rnd_issue n=%0d got v=%b rw=%b u=%0d rt=%0d want v=%b rw=%b u=%0d rt=%0d",
                           n, issue_valid, issue_reg_write, issue_unit, issue_rt_addr, m_iv, m_irw, m_iu, m_irt);
      end
      n_chk++; if (stall_cnt !== 4'(m_stall) || issue_cnt !== 4'(m_issue)) begin
        n_fail++; $display("FAIL rnd_cnt n=%0d got stall=%0d issue=%0d want %0d %0d", n, stall_cnt, issue_cnt, m_stall, m_issue);
      end
    end
    reset = 1'b0; ext_stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    foreach (rdy_at[i]) rdy_at[i] = 0;
    @(negedge clk);
    test_reset();
    test_independent();
    test_raw(U_PERM, 4);
    test_raw(U_LS, 6);
    test_br_waw();
    test_flush_stall();
    test_wrap_reset();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/odd_issue_ctrl.md
# odd_issue_ctrl

Issue controller for the odd pipe. It sits between decode and the odd-pipe execution units (permute, local store, branch) and accepts one decoded instruction per cycle over a valid/ready handshake. It holds back any instruction whose source or destination register is still being computed by an earlier odd-pipe instruction and not yet available on the forwarding path. Accepted instructions are presented to the odd pipe on a registered issue port, and the block also counts issued instructions and stall cycles for performance monitoring.

## Interface
Parameters:
- NSLOT, 8: scoreboard entries, power of two, must be ≥ LAT_LS.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- in_valid  in  1  decoded odd-pipe instruction present.
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
- in_unit  in  2  0 perm, 1 ls, 2 br, 3 treated as perm.
- in_rt_addr  in  7  destination register.
- in_ra_addr, in_rb_addr, in_rc_addr  in  7 each  source registers; rc is the store-data source (rt_st).
- in_ra_use, in_rb_use, in_rc_use  in  1 each  source is actually read.
- in_reg_write  in  1  instruction writes in_rt_addr.
- ext_stall  in  1  external hold, e.g. even-pipe hazard.
- flush  in  1  branch taken/kill; blocks acceptance this cycle.
- issue_valid  out  1  registered; instruction issuing to the odd pipe.
- issue_unit  out  2  registered copy of in_unit.
- issue_rt_addr  out  7  registered.
- issue_reg_write  out  1  registered; forced 0 when issue_valid=0.
- stall_cnt  out  CNT_W  saturating count of cycles with in_valid && !in_ready.
- issue_cnt  out  CNT_W  saturating count of accepts.

## Operation
- Latency L by unit: perm 4, ls 6, br 1. Unit 3 uses the perm latency.
- Scoreboard: NSLOT entries, each holding {addr[7], cnt[3]}. An entry is busy when cnt≠0.
- Allocation on accept with in_reg_write=1 and L>1:
  - Write {in_rt_addr, L-1} into the entry at wr_ptr.
  - Increment wr_ptr modulo NSLOT.
  - Branch (L=1) and non-writing instructions allocate nothing.
- Every cycle, every busy entry decrements by 1. The decrement of old entries and the write of a new entry happen on the same edge.
- Hazard is computed combinationally from the entry state in the current cycle:
  - RAW: for any used source, some busy entry has addr equal to that source.
  - WAW: in_reg_write=1 and some busy entry has addr equal to in_rt_addr.
- in_ready = !hazard && !ext_stall && !flush.
- in_ready is independent of in_valid, so there is no combinational loop.
- Accept: register the issue fields on the next edge. When nothing is accepted, issue_valid and issue_reg_write are 0 in the next cycle.
- flush does not clear the scoreboard. In-flight results still write back.
- Counters saturate at all-ones and never wrap.
- Register 0 is not special; all 128 registers are tracked.

## Timing
- Reset values: in_ready 0 during reset; issue_valid 0, issue_unit 0, issue_rt_addr 0, issue_reg_write 0, stall_cnt 0, issue_cnt 0; all entries cnt 0; wr_ptr 0.
- Reset asserted mid-operation: all entries free next cycle; no issue.
- Accept to issue: 1 cycle. Producer accepted at cycle t; a dependent consumer can be accepted at the earliest at t+L. This gives t+4 for perm, t+6 for ls, and t+1 (back-to-back) for br.
- Freed entries are reusable by the accept in the same cycle they free.
- wr_ptr wraps NSLOT-1 → 0. With NSLOT ≥ 6 a busy entry is never overwritten, because at most 6 entries are ever busy. Assertion: the entry at wr_ptr has cnt=0 whenever an allocation occurs.
- Simultaneous flush and ext_stall: in_ready 0; stall_cnt increments once if in_valid.
- Stall counting: stall_cnt increments on every cycle in_valid && !in_ready, whatever the cause.

## Structure
- odd_pkg holds:
  - Unit encoding enum: UNIT_PERM, UNIT_LS, UNIT_BR.
  - LAT_PERM=4, LAT_LS=6, LAT_BR=1.
  - Function lat_of(unit).
  - Register address width 7.
- Sub-module odd_scoreboard:
  - Owns the entry table, wr_ptr and the decrement logic.
  - Inputs: alloc, alloc_addr, alloc_cnt.
  - Combinational outputs: busy match for four query addresses.
- odd_issue_ctrl holds the handshake, issue registers and counters.

## Test plan
- Independent stream: 10 perm instructions with distinct rt/ra each cycle → in_ready held 1, issue_valid 1 from cycle 2 through 11, issue_cnt=10, stall_cnt=0.
- RAW perm: perm rt=5 accepted at t, next instruction reads ra=5 → in_ready 0 for t+1..t+3, accepted at t+4, stall_cnt=3. Repeat with ls → accepted at t+6, stall_cnt=5.
- Branch and WAW: br rt=9 then a consumer of 9 → accepted at t+1. ls rt=7 then perm rt=7 (WAW) → perm accepted at t+6.
- Flush / ext_stall: flush pulsed for 1 cycle with a valid, hazard-free instruction → not accepted that cycle, accepted next; scoreboard entries of earlier producers unchanged (timing of a pending RAW unaffected). ext_stall held 3 cycles → stall_cnt +3.
- Wrap and reset: ls writes to r1..r6 back-to-back, then more instructions forcing wr_ptr past 7 → no lost hazards, overwrite assertion never fires. Reset asserted mid-stream → next cycle all outputs 0 and a consumer of r6 is accepted immediately after reset deasserts.
- Saturation: with CNT_W=4, 20 stall cycles → stall_cnt=15.
